mainmemory_pipe: RTL and testbench

Parametrised, pipelined main-memory model for cache fill/writeback testbenches. It replaces the fixed 256-bit, fixed-latency memory model with configurable line width, depth and read latency. It adds a valid/ready request handshake, a backpressured in-order response queue, and out-of-range address detection. It sits below the cache controller's fill/evict port and is used in simulation only.

---
 rtl/mainmemory_pipe.sv | 106 ++++++++++
 tb/tb_mainmemory_pipe.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mainmemory_pipe.sv
// mainmemory_pipe: parametrised line memory with credit-gated requests,
// a fixed-latency read pipeline and an in-order fall-through response queue.
module mainmemory_pipe #(
  parameter int DATA_WIDTH = 256,
  parameter int ENTRIES    = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_LATENCY = 2,
  parameter int RESP_DEPTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic                    i_req_write,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [DATA_WIDTH/8-1:0] i_req_be,
  input  logic [DATA_WIDTH-1:0]   i_req_wd,
  output logic                    o_resp_valid,
  input  logic                    i_resp_ready,
  output logic [DATA_WIDTH-1:0]   o_resp_rd,
  output logic [ADDR_WIDTH-1:0]   o_resp_addr,
  output logic                    o_resp_err
);
  localparam int IDX_W = ENTRIES > 1 ? $clog2(ENTRIES) : 1;
  localparam int PW    = RESP_DEPTH > 1 ? $clog2(RESP_DEPTH) : 1;
  localparam int CW    = $clog2(RESP_DEPTH + 1);
  localparam int NB    = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [ENTRIES];
  logic [CW-1:0]         r_cred, r_cnt;
  logic [PW-1:0]         r_wp, r_rp;
  logic [DATA_WIDTH-1:0] r_qd [RESP_DEPTH];
  logic [ADDR_WIDTH-1:0] r_qa [RESP_DEPTH];
  logic                  r_qe [RESP_DEPTH];
  logic                  w_acc, w_rd, w_wr, w_oor, w_pop, w_push;
  logic                  w_pv [RD_LATENCY];
  logic [DATA_WIDTH-1:0] w_pd [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] w_pa [RD_LATENCY];
  logic                  w_pe [RD_LATENCY];

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(RESP_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign w_oor       = {1'b0, i_req_addr} >= (ADDR_WIDTH + 1)'(ENTRIES);
  assign o_req_ready = r_cred != '0;
  assign w_acc       = i_req_valid & o_req_ready;
  assign w_rd        = w_acc & ~i_req_write;
  assign w_wr        = w_acc & i_req_write & ~w_oor;
  assign w_pop       = o_resp_valid & i_resp_ready;

  // Stage 0 is the accepting cycle itself; the last stage writes the queue.
  assign w_pv[0] = w_rd;
  assign w_pd[0] = w_oor ? '0 : r_mem[i_req_addr[IDX_W-1:0]];
  assign w_pa[0] = i_req_addr;
  assign w_pe[0] = w_oor;
  assign w_push  = w_pv[RD_LATENCY-1];

  for (genvar s = 1; s < RD_LATENCY; s++) begin : g_stage
    logic                  r_v, r_e;
    logic [DATA_WIDTH-1:0] r_d;
    logic [ADDR_WIDTH-1:0] r_a;
    always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_v <= 1'b0;
      else r_v <= w_pv[s-1];
    always_ff @(posedge i_clk) begin
      r_d <= w_pd[s-1];
      r_a <= w_pa[s-1];
      r_e <= w_pe[s-1];
    end
    assign w_pv[s] = r_v;
    assign w_pd[s] = r_d;
    assign w_pa[s] = r_a;
    assign w_pe[s] = r_e;
  end

  always_ff @(posedge i_clk)
    if (w_wr)
      for (int b = 0; b < NB; b++)
        if (i_req_be[b]) r_mem[i_req_addr[IDX_W-1:0]][8*b +: 8] <= i_req_wd[8*b +: 8];

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_cred <= CW'(RESP_DEPTH);
      r_cnt  <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
    end else begin
      r_cred <= r_cred + CW'(w_pop) - CW'(w_rd);
      r_cnt  <= r_cnt + CW'(w_push) - CW'(w_pop);
      if (w_push) r_wp <= nxt(r_wp);
      if (w_pop) r_rp <= nxt(r_rp);
    end

  always_ff @(posedge i_clk)
    if (w_push) begin
      r_qd[r_wp] <= w_pd[RD_LATENCY-1];
      r_qa[r_wp] <= w_pa[RD_LATENCY-1];
      r_qe[r_wp] <= w_pe[RD_LATENCY-1];
    end

  assign o_resp_valid = r_cnt != '0;
  assign o_resp_rd    = o_resp_valid ? r_qd[r_rp] : '0;
  assign o_resp_addr  = o_resp_valid ? r_qa[r_rp] : '0;
  assign o_resp_err   = o_resp_valid & r_qe[r_rp];
endmodule

// File: tb/tb_mainmemory_pipe.sv
// tb_mainmemory_pipe: randomized and directed stimulus against a queue/array
// reference model of the memory, checked every cycle.
module tb_mainmemory_pipe;
  localparam int DW = 256, NB = 32, AW = 32, ENT = 256, LAT = 2, DEP = 4;

  logic clk = 0, rst_n = 1, req_valid = 0, req_write = 0, resp_ready = 0;
  logic [AW-1:0] req_addr = '0;
  logic [NB-1:0] req_be = '0;
  logic [DW-1:0] req_wd = '0;
  logic req_ready, resp_valid, resp_err;
  logic [DW-1:0] resp_rd;
  logic [AW-1:0] resp_addr;

  mainmemory_pipe dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_write(req_write), .i_req_addr(req_addr), .i_req_be(req_be), .i_req_wd(req_wd),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready), .o_resp_rd(resp_rd),
    .o_resp_addr(resp_addr), .o_resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] d; logic [AW-1:0] a; logic e; int rdy; } rsp_t;
  rsp_t q[$];
  rsp_t lg[$];
  logic [DW-1:0] mem [ENT];
  int cyc = 0, n_chk = 0, n_fail = 0;

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] merge(logic [DW-1:0] o, logic [DW-1:0] w, logic [NB-1:0] be);
    for (int b = 0; b < NB; b++) if (be[b]) o[8*b +: 8] = w[8*b +: 8];
    return o;
  endfunction

  // Model: outstanding reads form one in-order queue; each becomes visible LAT cycles after accept.
  always @(posedge clk) begin
    bit rdy_pre;
    rsp_t r;
    rdy_pre = q.size() < DEP;
    if (!rst_n) q.delete();
    else begin
      if (q.size() > 0 && q[0].rdy <= cyc && resp_ready) void'(q.pop_front());
      if (req_valid && rdy_pre) begin
        if (req_write) begin
          if (req_addr < ENT) mem[req_addr] = merge(mem[req_addr], req_wd, req_be);
        end else begin
          r.e = req_addr >= ENT;
          r.d = r.e ? '0 : mem[req_addr];
          r.a = req_addr;
          r.rdy = cyc + LAT;
          q.push_back(r);
        end
      end
    end
    cyc++;
  end

  always @(negedge rst_n) q.delete();

  always @(negedge clk) begin
    bit ev;
    rsp_t r;
    if (rst_n) begin
      ev = q.size() > 0 && q[0].rdy <= cyc;
      r.d = '0; r.a = '0; r.e = 1'b0;
      if (ev) r = q[0];
      chk("req_ready", req_ready, q.size() < DEP);
      chk("resp_valid", resp_valid, ev);
      chk("resp_rd", resp_rd, r.d);
      chk("resp_addr", resp_addr, r.a);
      chk("resp_err", resp_err, r.e);
      if (resp_valid && resp_ready) begin
        r.d = resp_rd; r.a = resp_addr; r.e = resp_err; r.rdy = cyc;
        lg.push_back(r);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic req(bit w, logic [AW-1:0] a, logic [NB-1:0] be, logic [DW-1:0] wd);
    bit ok = 0;
    req_valid = 1; req_write = w; req_addr = a; req_be = be; req_wd = wd;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = q.size() < DEP;
      tick();
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL req_timeout: got no accept expected accept for addr %0d", a);
    end
  endtask

  task automatic idle;
    req_valid = 0; req_write = 0;
  endtask

  initial begin
    int base;
    #1 rst_n = 0;
    tick(); tick();
    @(negedge clk);
    chk("rst_valid", resp_valid, 0);
    chk("rst_rd", resp_rd, 0);
    chk("rst_addr", resp_addr, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_ready", req_ready, 1);
    rst_n = 1;
    tick();
    for (int a = 0; a < ENT; a++) req(1, a, '1, {32{8'(a)}});
    idle();
    // single write then read: response in cycle 2
    resp_ready = 1;
    req(1, 3, '1, {32{8'hA5}});
    req(0, 3, '0, '0);
    idle();
    @(negedge clk);
    chk("lat_c1_valid", resp_valid, 0);
    tick();
    @(negedge clk);
    chk("lat_c2_valid", resp_valid, 1);
    chk("lat_c2_rd", resp_rd, {32{8'hA5}});
    chk("lat_c2_addr", resp_addr, 3);
    chk("lat_c2_err", resp_err, 0);
    tick();
    // byte-enable merge
    req(1, 5, '1, {32{8'h11}});
    req(1, 5, 32'h1, {32{8'hFF}});
    req(0, 5, '0, '0);
    idle();
    tick();
    @(negedge clk);
    chk("be_merge", resp_rd, {{31{8'h11}}, 8'hFF});
    tick();
    // pipelined throughput
    repeat (3) tick();
    lg.delete();
    base = cyc;
    for (int i = 0; i < 4; i++) req(0, i, '0, '0);
    idle();
    repeat (4) tick();
    chk("tp_count", lg.size(), 4);
    for (int i = 0; i < lg.size(); i++) begin
      chk("tp_cycle", lg[i].rdy, base + 2 + i);
      chk("tp_addr", lg[i].a, i);
    end
    // backpressure
    resp_ready = 0;
    lg.delete();
    for (int i = 0; i < 4; i++) req(0, 10 + i, '0, '0);
    req_addr = 14;
    @(negedge clk);
    chk("bp_ready_low", req_ready, 0);
    repeat (3) tick();
    @(negedge clk);
    chk("bp_hold_rd", resp_rd, {32{8'd10}});
    chk("bp_hold_addr", resp_addr, 10);
    tick();
    resp_ready = 1;
    req(0, 14, '0, '0);
    req(0, 15, '0, '0);
    idle();
    repeat (8) tick();
    chk("bp_count", lg.size(), 6);
    for (int i = 0; i < lg.size(); i++) begin
      chk("bp_order_addr", lg[i].a, 10 + i);
      chk("bp_order_rd", lg[i].d, {32{8'(10 + i)}});
    end
    @(negedge clk);
    chk("bp_ready_back", req_ready, 1);
    tick();
    // out of range
    req(0, 256, '0, '0);
    idle();
    tick();
    @(negedge clk);
    chk("oor_valid", resp_valid, 1);
    chk("oor_err", resp_err, 1);
    chk("oor_rd", resp_rd, 0);
    chk("oor_addr", resp_addr, 256);
    tick();
    req(1, 300, '1, {32{8'hEE}});
    req(0, 44, '0, '0);
    idle();
    tick();
    @(negedge clk);
    chk("oor_wr_dropped", resp_rd, {32{8'd44}});
    tick();
    // reset with reads in flight
    repeat (3) tick();
    req(0, 20, '0, '0);
    req(0, 21, '0, '0);
    req(0, 22, '0, '0);
    idle();
    #2 rst_n = 0;
    lg.delete();
    #1;
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_rd", resp_rd, 0);
    chk("mid_rst_ready", req_ready, 1);
    @(posedge clk);
    #2 rst_n = 1;
    repeat (8) tick();
    chk("mid_rst_no_stale", lg.size(), 0);
    req(0, 3, '0, '0);
    idle();
    tick();
    @(negedge clk);
    chk("mid_rst_persist", resp_rd, {32{8'hA5}});
    tick();
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      req_valid  = $urandom_range(0, 3) != 0;
      req_write  = $urandom_range(0, 2) == 0;
      req_addr   = $urandom_range(0, 9) == 0 ? $urandom_range(256, 299) : $urandom_range(0, 15);
      req_be     = $urandom();
      for (int k = 0; k < 8; k++) req_wd[32*k +: 32] = $urandom();
      resp_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    idle();
    resp_ready = 1;
    repeat (10) tick();
    chk("drain_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
